// File: rtl/jtvigil_arb_pkg.sv
// Shared types and defaults for the graphics-ROM arbiter.
package jtvigil_arb_pkg;

  localparam int ARB_NREQ_DEF = 3;
  localparam int ARB_AW_DEF   = 17;
  localparam int ARB_DW_DEF   = 32;

  // IDLE: port free; BLANK: first cycle of a grant, rom_ok ignored;
  // WAIT: waiting for rom_ok from the downstream port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BLANK = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jtvigil_arb_slot.sv
// One requester's cache slot: last fetched address/word plus a valid bit.
// The hit compare is combinational so a repeated address answers at once.
module jtvigil_arb_slot
  import jtvigil_arb_pkg::*;
#(
  parameter int AW = ARB_AW_DEF,
  parameter int DW = ARB_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  output logic          ok_o,
  output logic [DW-1:0] data_o
);

  logic [AW-1:0] last_q;
  logic [DW-1:0] data_q;
  logic          valid_q;

  // Load wins over clear; the FSM never asserts both on the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      last_q  <= load_addr_i;
      data_q  <= load_data_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign ok_o   = cs_i & valid_q & (last_q == addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Graphics-ROM read-port arbiter for the scroll and object fetch engines.
// Optional build macro: JTVIGIL_ARB_PRIO_EN selects fixed priority (lowest
// index wins); without it the winner is picked round-robin from ptr_q.
//
// Handshake: a requester holds req_cs with a stable req_addr until req_ok;
// req_ok means req_data is the word for the address presented this cycle.
// Downstream, rom_cs/rom_addr are held until rom_ok is taken in ARB_WAIT.
// state_q is the FSM probe point (arb_state_e).
module jtvigil_rom_arb
  import jtvigil_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEF,
  parameter int AW   = ARB_AW_DEF,
  parameter int DW   = ARB_DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_cs,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ok,
  output logic [AW-1:0]      rom_addr,
  output logic               rom_cs,
  input  logic [DW-1:0]      rom_data,
  input  logic               rom_ok,
  output logic [NREQ-1:0]    grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic             rom_cs_q, rom_cs_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]    gidx_q, gidx_d;
`ifndef JTVIGIL_ARB_PRIO_EN
  logic [IW-1:0]    ptr_q, ptr_d;
  int               rr_idx;
`endif

  logic [AW-1:0]    addr_a [NREQ];
  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  clear_v, load_v;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic             abort;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign addr_a[g] = req_addr[g*AW +: AW];

    jtvigil_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .cs_i        (req_cs[g]),
      .addr_i      (addr_a[g]),
      .clear_i     (clear_v[g]),
      .load_i      (load_v[g]),
      .load_addr_i (rom_addr_q),
      .load_data_i (rom_data),
      .ok_o        (req_ok[g]),
      .data_o      (req_data[g*DW +: DW])
    );
  end

  assign pending = req_cs & ~req_ok;

  // Winner selection among requesters that want the port and do not hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef JTVIGIL_ARB_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (pending[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    rr_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      cand = IW'(rr_idx);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  // The owner gives up by dropping req_cs or moving to another address.
  assign abort = !req_cs[gidx_q] || (addr_a[gidx_q] != rom_addr_q);

  // Next-state and downstream control; abort beats a same-cycle rom_ok.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    clear_v    = '0;
    load_v     = '0;
`ifndef JTVIGIL_ARB_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
          rom_addr_d       = addr_a[win_idx];
          rom_cs_d         = 1'b1;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          clear_v[win_idx] = 1'b1;
          state_d          = ARB_BLANK;
        end
      end
      ARB_BLANK: begin
        // rom_ok here may still belong to the previous address.
        if (abort) begin
          rom_cs_d = 1'b0;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end else begin
          state_d  = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (abort) begin
          rom_cs_d = 1'b0;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end else if (rom_ok) begin
          load_v[gidx_q] = 1'b1;
          rom_cs_d       = 1'b0;
          grant_d        = '0;
          state_d        = ARB_IDLE;
`ifndef JTVIGIL_ARB_PRIO_EN
          ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
`endif
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        grant_d  = '0;
        state_d  = ARB_IDLE;
      end
    endcase
  end

  // FSM and downstream port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      grant_q    <= '0;
      gidx_q     <= '0;
`ifndef JTVIGIL_ARB_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
`ifndef JTVIGIL_ARB_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Bench for jtvigil_rom_arb: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_jtvigil_rom_arb;

  localparam int NREQ = 3;
  localparam int AW   = 17;
  localparam int DW   = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_cs;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ok;
  logic [AW-1:0]      rom_addr;
  logic               rom_cs;
  logic [DW-1:0]      rom_data;
  logic               rom_ok;
  logic [NREQ-1:0]    grant;

  jtvigil_rom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ok   (req_ok),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .grant    (grant)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [NREQ-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Returns at the falling edge of the first cycle with rom_cs high.
  task automatic wait_cs(input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (!rom_cs && k < lim) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (!rom_cs) begin
      n_err++;
      $display("FAIL wait_cs: rom_cs never rose within %0d cycles", lim);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A fetch is a transaction owned by one requester; m_age counts cycles
  // since it was granted (0 = first cycle, where rom_ok means nothing).
  logic [AW-1:0] m_last [NREQ];
  logic [DW-1:0] m_data [NREQ];
  bit            m_valid[NREQ];
  int            m_owner;
  int            m_age;
  logic [AW-1:0] m_addr;
  int            m_ptr;

  function automatic bit m_hit(input int i);
    return req_cs[i] && m_valid[i] && (m_last[i] == addr_of(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_last[i]  = '0;
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_owner = -1;
    m_age   = 0;
    m_addr  = '0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    int o, w, j;
    if (m_owner >= 0) begin
      o = m_owner;
      if (!req_cs[o] || addr_of(o) != m_addr) begin
        m_owner = -1;
      end else if (m_age >= 1 && rom_ok) begin
        m_data[o]  = rom_data;
        m_last[o]  = m_addr;
        m_valid[o] = 1'b1;
        m_ptr      = (o + 1) % NREQ;
        m_owner    = -1;
      end else begin
        m_age++;
      end
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef JTVIGIL_ARB_PRIO_EN
        j = k;
`else
        j = (m_ptr + k) % NREQ;
`endif
        if (w < 0 && req_cs[j] && !m_hit(j)) w = j;
      end
      if (w >= 0) begin
        m_owner    = w;
        m_age      = 0;
        m_addr     = addr_of(w);
        m_valid[w] = 1'b0;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0]    e_ok;
    logic [NREQ-1:0]    e_grant;
    logic [NREQ*DW-1:0] e_data;
    if (!rst_n) model_reset();
    for (int i = 0; i < NREQ; i++) begin
      e_ok[i]             = m_hit(i);
      e_data[i*DW +: DW]  = m_data[i];
    end
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    check("cyc_rom_cs",   rom_cs,   m_owner >= 0);
    check("cyc_rom_addr", rom_addr, m_addr);
    check("cyc_grant",    grant,    e_grant);
    check("cyc_req_ok",   req_ok,   e_ok);
    check("cyc_req_data", req_data, e_data);
    if (rst_n) model_step();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0] g, prev, exp;
    int age, got;
    bit chg;
    model_reset();
    req_cs   = '0;
    req_addr = '0;
    rom_ok   = 1'b0;
    rom_data = '0;
    #1 rst_n = 1'b0;

    @(negedge clk);
    check("rst_rom_cs",   rom_cs,   0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_grant",    grant,    0);
    check("rst_req_ok",   req_ok,   0);
    check("rst_req_data", req_data, 0);
    step();
    rst_n = 1'b1;

    // Miss on requester 0, rom_ok four cycles after rom_cs rises.
    req_cs[0] = 1'b1;
    set_addr(0, 17'h00100);
    wait_cs(10);
    check("t1_rom_addr", rom_addr, 17'h00100);
    check("t1_grant",    grant,    3'b001);
    repeat (4) step();
    rom_ok   = 1'b1;
    rom_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_ok_in_wait", req_ok[0], 0);
    check("t1_addr_held",  rom_addr,  17'h00100);
    step();
    rom_ok   = 1'b0;
    rom_data = '0;
    @(negedge clk);
    check("t1_ok_after", req_ok[0],      1);
    check("t1_data",     req_data[31:0], 32'hDEADBEEF);
    check("t1_cs_drop",  rom_cs,         0);

    // Repeated address hits with no new access.
    step();
    @(negedge clk);
    check("t2_hit",    req_ok[0], 1);
    check("t2_no_cs",  rom_cs,    0);
    step();
    req_cs[0] = 1'b0;
    @(negedge clk);
    check("t2_cs_low", req_ok[0], 0);
    step();
    req_cs[0] = 1'b1;
    @(negedge clk);
    check("t2_rehit",  req_ok[0], 1);
    step();
    @(negedge clk);
    check("t2_no_cs2", rom_cs, 0);

    // Fresh reset so the round-robin pointer restarts at 0.
    step();
    req_cs = '0;
    rst_n  = 1'b0;
    step();
    rst_n  = 1'b1;

    // All three miss; requester 0 keeps re-missing.
`ifdef JTVIGIL_ARB_PRIO_EN
    exp_q = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    step();
    set_addr(0, 17'h00200);
    set_addr(1, 17'h00300);
    set_addr(2, 17'h00400);
    req_cs   = 3'b111;
    rom_ok   = 1'b1;
    rom_data = $urandom;
    prev = '0;
    age  = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      g   = grant;
      chg = 1'b0;
      if (g != 0) age++; else age = 0;
      if (g != 0 && prev == 0) begin
        exp = exp_q.pop_front();
        check("t3_grant_order", g, exp);
        got++;
      end
      if (g[0] && age == 2) chg = 1'b1;
      prev = g;
      step();
      rom_data = $urandom;
      if (chg) set_addr(0, addr_of(0) + 17'd1);
    end
    if (got < 4) begin
      n_vec++;
      n_err++;
      $display("FAIL t3_timeout: saw %0d grants, needed 4", got);
      exp_q.delete();
    end
    req_cs = '0;
    rom_ok = 1'b0;
    repeat (4) step();

    // Requester 1 moves its address in the same WAIT cycle as rom_ok.
    req_cs = 3'b010;
    set_addr(1, 17'h00500);
    wait_cs(10);
    check("t4_grant", grant, 3'b010);
    step();
    set_addr(1, 17'h00501);
    rom_ok   = 1'b1;
    rom_data = 32'h0BAD0BAD;
    @(negedge clk);
    check("t4_ok_abort", req_ok[1], 0);
    step();
    rom_ok = 1'b0;
    @(negedge clk);
    check("t4_idle_cs",    rom_cs,    0);
    check("t4_idle_grant", grant,     0);
    check("t4_not_stored", req_ok[1], 0);
    step();
    @(negedge clk);
    check("t4_regrant_cs",   rom_cs,   1);
    check("t4_regrant",      grant,    3'b010);
    check("t4_regrant_addr", rom_addr, 17'h00501);
    step();
    rom_ok   = 1'b1;
    rom_data = 32'hCAFE0001;
    @(negedge clk);
    step();
    rom_ok = 1'b0;
    @(negedge clk);
    check("t4_ok_new",   req_ok[1],       1);
    check("t4_data_new", req_data[63:32], 32'hCAFE0001);

    // rom_ok stuck high: only the WAIT-cycle word is captured.
    step();
    req_cs = 3'b100;
    set_addr(2, 17'h00600);
    rom_ok   = 1'b1;
    rom_data = 32'h11111111;
    wait_cs(10);
    check("t5_grant", grant, 3'b100);
    step();
    rom_data = 32'h22222222;
    @(negedge clk);
    check("t5_no_blank_capture", req_ok[2], 0);
    step();
    @(negedge clk);
    check("t5_ok",   req_ok[2],       1);
    check("t5_data", req_data[95:64], 32'h22222222);

    // Reset in the middle of a stalled fetch.
    step();
    set_addr(2, 17'h00601);
    rom_ok = 1'b0;
    wait_cs(10);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rom_cs",   rom_cs,   0);
    check("t6_rom_addr", rom_addr, 0);
    check("t6_grant",    grant,    0);
    check("t6_req_ok",   req_ok,   0);
    check("t6_req_data", req_data, 0);
    step();
    rst_n = 1'b1;

    // Random traffic from a small address pool per requester.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req_cs[i] = ~req_cs[i];
        if ($urandom_range(0, 15) == 0)
          set_addr(i, AW'(17'h01000 * (i + 1) + $urandom_range(0, 3)));
      end
      rom_ok   = ($urandom_range(0, 2) == 0);
      rom_data = $urandom;
    end
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtvigil_rom_arb.md
# jtvigil_rom_arb

Shares one graphics-ROM SDRAM read port among several tile/sprite fetch engines (scroll layer 1, scroll layer 2 and objects by default). Each requester sees a private ROM interface with an address, a data word and an `ok` flag. The arbiter grants requests, sequences the single downstream port and keeps the last fetched word per requester, so a repeated address hits without a new SDRAM access. It sits between the video layer modules and the jtframe SDRAM bank mux.

## Interface

Parameters:

- `NREQ`, 3: number of requesters; index 0 is scr1, 1 is scr2, 2 is obj.
- `AW`, 17: ROM word-address width.
- `DW`, 32: ROM data width.

Ports:

- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_cs` in NREQ: per-requester fetch request.
- `req_addr` in NREQ*AW: flattened addresses; requester i uses bits [i*AW +: AW].
- `req_data` out NREQ*DW: flattened latched data, one word per requester.
- `req_ok` out NREQ: `req_data` slice i is valid for the current `req_addr` slice i.
- `rom_addr` out AW: downstream address, registered.
- `rom_cs` out 1: downstream request, registered.
- `rom_data` in DW: downstream data.
- `rom_ok` in 1: downstream data valid.
- `grant` out NREQ: one-hot owner of the downstream port; all zero when idle.

## Operation

Per-requester slot:
- Each slot holds `last_addr`, `data` and `valid`.
- Hit condition: `req_ok[i] = req_cs[i] & valid[i] & (last_addr[i] == req_addr[i])`. This is combinational and adds zero latency.
- A requester is pending when `req_cs[i]` is high and it does not hit.

FSM states and transitions:
- IDLE:
  - If any requester is pending, select a winner (see Configuration).
  - Register `rom_addr` from the winner's address, set `rom_cs=1`, set `grant` to the winner, clear the winner's `valid`, and go to BLANK.
- BLANK:
  - Ignore `rom_ok` for exactly one cycle, because a stale `rom_ok` from the previous address is possible.
  - Go to WAIT.
- WAIT, abort check:
  - Abort if the granted requester's `req_addr` differs from `rom_addr`, or its `req_cs` dropped.
  - On abort: `rom_cs=0`, `grant=0`, go to IDLE, nothing is stored.
- WAIT, completion:
  - Otherwise, if `rom_ok` is high: `data<=rom_data`, `last_addr<=rom_addr`, `valid<=1`, `rom_cs=0`, `grant=0`, go to IDLE.

Edge rules:
- Abort takes precedence over a same-cycle `rom_ok`.
- In BLANK, the abort check also applies: an address change in BLANK aborts.
- `rom_cs` always deasserts for at least one cycle between two grants.
- Slots of non-granted requesters are never modified.
- Reset:
  - All outputs are 0: `rom_cs`, `rom_addr`, `grant`, `req_ok`, `req_data`.
  - All `valid=0` and `last_addr=0`.
  - FSM in IDLE, round-robin pointer at 0.
  - Reset mid-transaction discards the fetch.

## Timing

- Minimum miss latency:
  - Cycle 0: request in IDLE.
  - Cycle 1: BLANK, with `rom_cs` high.
  - Cycle 2: WAIT, samples `rom_ok`.
  - Cycle 3: `req_ok` high.
- Hit latency: 0 cycles (same cycle the address is presented).
- No timeout. A stalled `rom_ok` holds the grant indefinitely unless the requester aborts.
- `rom_addr` is stable for the whole BLANK/WAIT period.

## Configuration

- `JTVIGIL_ARB_PRIO_EN` defined:
  - Fixed priority, the lowest index wins (scr1 > scr2 > obj).
  - The round-robin pointer is not implemented.
- `JTVIGIL_ARB_PRIO_EN` undefined (default):
  - Round-robin. The search starts at `ptr`, and after a completed grant to i, `ptr <= (i+1) mod NREQ`.
  - An aborted grant leaves `ptr` unchanged.

## Structure

- Package `jtvigil_arb_pkg` holds:
  - the FSM state enum (IDLE, BLANK, WAIT);
  - `ARB_NREQ_DEF=3`, `ARB_AW_DEF=17`, `ARB_DW_DEF=32`.
- Sub-module `jtvigil_arb_slot`, instantiated NREQ times, contains:
  - the `last_addr`/`data`/`valid` registers;
  - the hit compare;
  - load and clear controls driven by the FSM.
- Top level contains the FSM, winner selection and downstream registers.

## Test plan

- Reset, then `req_cs[0]=1` with addr 0x00100 and `rom_ok` high 4 cycles after `rom_cs` rises, data 0xDEADBEEF:
  - `rom_addr=0x00100`;
  - `req_ok[0]` rises 1 cycle after `rom_ok` is sampled in WAIT;
  - `req_data[0]=0xDEADBEEF`.
- Repeat addr 0x00100 on requester 0: `req_ok[0]` high in the same cycle and `rom_cs` stays 0.
- All three requesters miss simultaneously, default build: grants go in order 0, 1, 2, then 0 again on the next round.
- Same stimulus with `JTVIGIL_ARB_PRIO_EN`, requester 0 re-missing continuously: requester 0 always wins.
- Requester 1 changes its address in the same WAIT cycle that `rom_ok=1`:
  - abort;
  - `valid[1]=0` and `req_ok[1]=0`;
  - a new grant for the new address follows after one idle cycle.
- Hold `rom_ok=1` permanently from the previous access and issue a new miss: data is not captured in BLANK, only in WAIT. Then assert `rst_n=0` mid-WAIT: all outputs read 0 immediately.
